// File: rtl/comp2s_serial_arbiter.sv
// comp2s_serial_arbiter
// Round-robin arbiter in front of one bit-serial two's-complement negation
// engine. A captured operand is negated LSB first, one bit per clock, over
// WIDTH cycles. The result is then presented with a one-cycle done pulse
// and the ID of the requester that was served.
// Optional build macro: COMP2S_SAT_EN. When it is defined, negating the most
// negative operand saturates to the largest positive value instead of wrapping.
module comp2s_serial_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] out,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] op, op_n;
  logic [WIDTH-1:0] res, res_n;
  logic             carry, carry_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             id, id_n;
  logic             is_min, is_min_n;
  logic             last_id, last_id_n;
  logic [WIDTH-1:0] out_n;
  logic             ovf_n, done_n, done_id_n, busy_n, gnt0_n, gnt1_n;
  logic             sel, s;
  logic [WIDTH-1:0] a_sel, res_shift;

  // Register every piece of state; reset abandons any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op      <= '0;
      res     <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      id      <= 1'b0;
      is_min  <= 1'b0;
      last_id <= 1'b1;
      out     <= '0;
      ovf     <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      busy    <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
    end else begin
      state   <= state_n;
      op      <= op_n;
      res     <= res_n;
      carry   <= carry_n;
      cnt     <= cnt_n;
      id      <= id_n;
      is_min  <= is_min_n;
      last_id <= last_id_n;
      out     <= out_n;
      ovf     <= ovf_n;
      done    <= done_n;
      done_id <= done_id_n;
      busy    <= busy_n;
      gnt0    <= gnt0_n;
      gnt1    <= gnt1_n;
    end
  end

  // Arbitration in IDLE, one serial negation step per RUN cycle, result load on the last bit
  always_comb begin
    state_n   = state;
    op_n      = op;
    res_n     = res;
    carry_n   = carry;
    cnt_n     = cnt;
    id_n      = id;
    is_min_n  = is_min;
    last_id_n = last_id;
    out_n     = out;
    ovf_n     = ovf;
    done_n    = 1'b0;
    done_id_n = done_id;
    busy_n    = busy;
    gnt0_n    = 1'b0;
    gnt1_n    = 1'b0;
    sel       = 1'b0;
    s         = 1'b0;
    a_sel     = '0;
    res_shift = '0;
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (req0 || req1) begin
          sel       = (req0 && req1) ? ~last_id : req1;
          a_sel     = sel ? a1 : a0;
          op_n      = a_sel;
          id_n      = sel;
          carry_n   = 1'b1;
          cnt_n     = '0;
          is_min_n  = a_sel[WIDTH-1] & ~(|a_sel[WIDTH-2:0]);
          gnt0_n    = ~sel;
          gnt1_n    = sel;
          busy_n    = 1'b1;
          last_id_n = sel;
          state_n   = RUN;
        end
      end
      RUN: begin
        s         = ~op[0] ^ carry;
        carry_n   = ~op[0] & carry;
        res_shift = {s, res[WIDTH-1:1]};
        res_n     = res_shift;
        op_n      = op >> 1;
        cnt_n     = cnt + CW'(1);
        if (cnt == LAST) begin
`ifdef COMP2S_SAT_EN
          out_n = is_min ? {1'b0, {(WIDTH-1){1'b1}}} : res_shift;
`else
          out_n = res_shift;
`endif
          ovf_n     = is_min;
          done_id_n = id;
          done_n    = 1'b1;
          busy_n    = 1'b0;
          cnt_n     = '0;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_comp2s_serial_arbiter.sv
// tb_comp2s_serial_arbiter
// Scoreboard bench: the stimulus side predicts each grant and each negation
// result and queues them. A monitor on the falling edge pops an entry and
// compares it whenever the DUT pulses gnt or done.
module tb_comp2s_serial_arbiter;

  localparam int W = 8;
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] SATV = {1'b0, {(W-1){1'b1}}};

  logic clk = 1'b0;
  logic rst, req0, req1, gnt0, gnt1, busy, done, done_id, ovf;
  logic [W-1:0] a0, a1, out;

  comp2s_serial_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req0(req0), .a0(a0), .req1(req1), .a1(a1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .done_id(done_id),
    .out(out), .ovf(ovf)
  );

  // Free-running clock
  always #5 clk = ~clk;

  typedef struct { int id; int at; } gnt_t;
  typedef struct { int id; logic [W-1:0] val; logic ovf; int at; } res_t;

  gnt_t gq[$];
  res_t rq[$];

  int compared = 0;
  int mismatched = 0;
  int edgeCnt = 0;
  bit monitorOn = 0;

  int lastId, nextAccept, busyFrom, dropEdge, dropId;
  bit pend[2];
  logic [W-1:0] opv[2];
  bit refill = 0;
  bit randomMode = 0;

  // Count rising edges so expectations can be stamped with the edge they belong to
  always @(posedge clk) edgeCnt++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edgeCnt);
    end
  endtask

  task automatic failNote(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: event absent or unexpected (edge %0d)", name, edgeCnt);
  endtask

  function automatic logic [W-1:0] refNeg(input logic [W-1:0] a);
    logic [W-1:0] r;
    r = -a;
`ifdef COMP2S_SAT_EN
    if (a == MINV) r = SATV;
`endif
    return r;
  endfunction

  function automatic logic [W-1:0] pickOperand();
    case ($urandom_range(0, 4))
      0: return '0;
      1: return MINV;
      2: return '1;
      3: return W'(1);
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: pop and compare on every gnt/done pulse, flag overdue or unexpected events
  always @(negedge clk) begin : monitor
    gnt_t g;
    res_t r;
    logic busyExp;
    if (monitorOn) begin
      if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
        checkOutput("gnt_exclusive", 32'(gnt0 & gnt1), 32'(0));
        if (gq.size() == 0) failNote("unexpected_gnt");
        else begin
          g = gq.pop_front();
          checkOutput("gnt_id", 32'(gnt1), 32'(g.id));
          checkOutput("gnt_edge", 32'(edgeCnt), 32'(g.at));
        end
      end else if (gq.size() > 0 && gq[0].at <= edgeCnt) begin
        failNote("missing_gnt");
        void'(gq.pop_front());
      end
      if (done === 1'b1) begin
        if (rq.size() == 0) failNote("unexpected_done");
        else begin
          r = rq.pop_front();
          checkOutput("out", 32'(out), 32'(r.val));
          checkOutput("ovf", 32'(ovf), 32'(r.ovf));
          checkOutput("done_id", 32'(done_id), 32'(r.id));
          checkOutput("done_edge", 32'(edgeCnt), 32'(r.at));
        end
      end else if (rq.size() > 0 && rq[0].at <= edgeCnt) begin
        failNote("missing_done");
        void'(rq.pop_front());
      end
      busyExp = (edgeCnt >= busyFrom) && (edgeCnt < busyFrom + W);
      checkOutput("busy", 32'(busy), 32'(busyExp));
    end
  end

  // Drive one cycle of requests and predict whether the coming edge accepts one
  task automatic applyStimulus();
    int n;
    int w;
    bit r[2];
    n = edgeCnt;
    for (int i = 0; i < 2; i++) begin
      if (randomMode && !pend[i] && $urandom_range(0, 3) == 0) begin
        pend[i] = 1;
        opv[i] = pickOperand();
      end
      r[i] = pend[i] && !(dropEdge == n && dropId == i);
    end
    req0 = r[0];
    req1 = r[1];
    a0 = opv[0];
    a1 = opv[1];
    if (n + 1 >= nextAccept && (r[0] || r[1])) begin
      w = (r[0] && r[1]) ? 1 - lastId : (r[1] ? 1 : 0);
      gq.push_back('{id: w, at: n + 1});
      rq.push_back('{id: w, val: refNeg(opv[w]), ovf: (opv[w] == MINV), at: n + 1 + W});
      lastId = w;
      nextAccept = n + 2 + W;
      busyFrom = n + 1;
      dropEdge = n + 1;
      dropId = w;
      if (!refill) pend[w] = 0;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic doReset(input int cycles);
    rst = 1;
    req0 = 0;
    req1 = 0;
    pend[0] = 0;
    pend[1] = 0;
    gq.delete();
    rq.delete();
    lastId = 1;
    nextAccept = edgeCnt + cycles + 1;
    busyFrom = -100;
    dropEdge = -1;
    repeat (cycles) @(negedge clk);
    #1;
    rst = 0;
  endtask

  task automatic checkZeros();
    checkOutput("rst_gnt0", 32'(gnt0), 32'(0));
    checkOutput("rst_gnt1", 32'(gnt1), 32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_done", 32'(done), 32'(0));
    checkOutput("rst_done_id", 32'(done_id), 32'(0));
    checkOutput("rst_ovf", 32'(ovf), 32'(0));
    checkOutput("rst_out", 32'(out), 32'(0));
  endtask

  task automatic waitIdle();
    int guard;
    guard = 0;
    while ((pend[0] || pend[1] || gq.size() > 0 || rq.size() > 0) && guard < 400) begin
      applyStimulus();
      guard++;
    end
    if (guard >= 400) failNote("idle_timeout");
    repeat (2) applyStimulus();
  endtask

  // Directed scenarios followed by a randomized run
  initial begin
    int guard;
    rst = 1;
    req0 = 0;
    req1 = 0;
    a0 = '0;
    a1 = '0;
    opv[0] = '0;
    opv[1] = '0;
    doReset(2);
    monitorOn = 1;
    checkZeros();

    $display("[TB] single request a0=0xAA");
    pend[0] = 1; opv[0] = 8'hAA;
    waitIdle();

    $display("[TB] requester 1 with 0x00 then 0x01");
    pend[1] = 1; opv[1] = 8'h00;
    waitIdle();
    pend[1] = 1; opv[1] = 8'h01;
    waitIdle();

    $display("[TB] simultaneous requests from reset, alternating service");
    doReset(1);
    refill = 1;
    pend[0] = 1; opv[0] = 8'h05;
    pend[1] = 1; opv[1] = 8'h7F;
    repeat (5 * (W + 1) + 2) applyStimulus();
    refill = 0;
    waitIdle();

    $display("[TB] most negative operand");
    pend[0] = 1; opv[0] = MINV;
    waitIdle();

    $display("[TB] reset in the middle of a run");
    pend[0] = 1; opv[0] = 8'h10;
    busyFrom = -100;
    guard = 0;
    while ((busyFrom < 0 || edgeCnt < busyFrom + 3) && guard < 50) begin
      applyStimulus();
      guard++;
    end
    if (guard >= 50) failNote("accept_timeout");
    doReset(1);
    checkZeros();
    pend[0] = 1; opv[0] = 8'h33;
    pend[1] = 1; opv[1] = 8'hC4;
    waitIdle();
    repeat (20) applyStimulus();

    $display("[TB] randomized traffic");
    randomMode = 1;
    repeat (600) applyStimulus();
    randomMode = 0;
    waitIdle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
